// File: rtl/modred_final_csub.sv
// modred_final_csub
//   Final correction stage of the modular-reduction chain. Takes a partially
//   reduced value in [0, 4q) and returns the canonical residue in [0, q) using
//   two pipelined conditional subtractions. A small output FIFO with
//   valid/ready flow control decouples the always-advancing reduction
//   pipeline from a consumer that may stall.
//
// Ports:
//   clk        clock (all state updates on the rising edge)
//   reset      synchronous, active-high reset
//   q          modulus, DATA_SIZE_ARB bits; held stable while busy=1
//   in_valid   in_data is valid
//   in_ready   stage accepts in_data this cycle (registered state only)
//   in_data    partially reduced value, DATA_SIZE_ARB+2 bits, legal in [0, 4q)
//   out_valid  out_data is valid (FIFO non-empty)
//   out_ready  consumer takes out_data this cycle
//   out_data   canonical residue at the FIFO head
//   busy       S1 holds a value or the FIFO is non-empty
//   err        sticky flag: an accepted input was >= 4q
module modred_final_csub #(
  parameter int DATA_SIZE_ARB = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_SIZE_ARB-1:0] q,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_SIZE_ARB+1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_SIZE_ARB-1:0] out_data,
  output logic                     busy,
  output logic                     err
);

  localparam int W  = DATA_SIZE_ARB;
  localparam int WE = W + 3;                  // wide enough that 4q never overflows
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;                 // count must reach FIFO_DEPTH
  localparam int OW = CW + 1;                 // count + S1 occupancy

  // Extended operands
  logic [WE-1:0] q_x_s;
  logic [WE-1:0] q2_x_s;
  logic [WE-1:0] q4_x_s;
  logic [WE-1:0] in_x_s;
  logic [WE-1:0] s1_next_x_s;
  logic [WE-1:0] s1_x_s;
  logic [WE-1:0] r_x_s;

  // Pipeline and FIFO state
  logic              s1_valid_r;
  logic [W+1:0]      s1_data_r;
  logic [W-1:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              err_r;

  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic [OW-1:0]     occupancy_s;

  assign q_x_s  = {3'b000, q};
  assign q2_x_s = {2'b00, q, 1'b0};
  assign q4_x_s = {1'b0, q, 2'b00};
  assign in_x_s = {1'b0, in_data};
  assign s1_x_s = {1'b0, s1_data_r};

  // First conditional subtraction: bring [0, 4q) into [0, 2q)
  always_comb begin
    s1_next_x_s = in_x_s;
    if (in_x_s >= q2_x_s) begin
      s1_next_x_s = in_x_s - q2_x_s;
    end else begin
      s1_next_x_s = in_x_s;
    end
  end

  // Second conditional subtraction: bring [0, 2q) into [0, q)
  always_comb begin
    r_x_s = s1_x_s;
    if (s1_x_s >= q_x_s) begin
      r_x_s = s1_x_s - q_x_s;
    end else begin
      r_x_s = s1_x_s;
    end
  end

  // Counting the S1 slot as occupied reserves FIFO room for the value it will
  // push, so FIFO writes never need to be refused.
  assign occupancy_s = OW'(count_r) + OW'(s1_valid_r);
  assign in_ready    = (occupancy_s < OW'(FIFO_DEPTH));
  assign out_valid   = (count_r != {CW{1'b0}});
  assign out_data    = mem_r[rd_ptr_r];
  assign busy        = s1_valid_r | out_valid;
  assign err         = err_r;

  assign accept_s = in_valid & in_ready;
  assign push_s   = s1_valid_r;
  assign pop_s    = out_valid & out_ready;

  // Stage S1 register and sticky range-error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {(W+2){1'b0}};
      err_r      <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= s1_next_x_s[W+1:0];
        if (in_x_s >= q4_x_s) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  // Output FIFO storage, pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= r_x_s[W-1:0];
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_modred_final_csub.sv
// Self-checking bench for modred_final_csub (DATA_SIZE_ARB=14, q=12289).
// Expected residues are queued when an input is accepted and compared when
// the DUT pops an output; entries can also carry an accept-to-output latency
// check. Inputs are driven 1 time unit after the rising edge and all DUT
// outputs are sampled on the falling edge.
module tb_modred_final_csub;

  localparam int W = 14;
  localparam int Q = 12289;

  logic           clk;
  logic           reset;
  logic [W-1:0]   q;
  logic           in_valid;
  logic           in_ready;
  logic [W+1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           busy;
  logic           err;

  modred_final_csub #(.DATA_SIZE_ARB(W), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .q         (q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int  data;
    bit  care;
    int  cyc;
    bit  lat;
  } sb_entry_t;

  typedef struct {
    int din;
    int dout;
  } vec_t;

  sb_entry_t sb[$];
  int        n_cmp;
  int        n_bad;
  int        cyc;
  int        exp_data;
  bit        exp_care;
  bit        lat_chk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample handshakes on the falling edge, then advance
  task automatic tick(output bit acc);
    sb_entry_t e;
    @(negedge clk);
    acc = 1'b0;
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", int'(out_data), -1);
        end else begin
          e = sb.pop_front();
          if (e.care) check("out_data", int'(out_data), e.data);
          if (e.lat) check("latency", cyc - e.cyc, 2);
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        e.data = exp_data;
        e.care = exp_care;
        e.cyc  = cyc;
        e.lat  = lat_chk;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_in(input int din, input int dexp, input bit dcare);
    in_valid = 1'b1;
    in_data  = (W+2)'(din);
    exp_data = dexp;
    exp_care = dcare;
  endtask

  // Offer one value until accepted, bounded
  task automatic send(input int din, input int dexp, input bit dcare);
    bit acc;
    int n;
    set_in(din, dexp, dcare);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 40) begin
      tick(acc);
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    vec_t vecs[5];
    int   bp_vals[6];
    int   k;
    int   nacc;
    int   d;
    bit   acc;

    n_cmp = 0; n_bad = 0; cyc = 0;
    exp_data = 0; exp_care = 1'b0; lat_chk = 1'b0;
    reset = 1'b1; q = W'(Q); in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    vecs[0] = '{0,     0};
    vecs[1] = '{12289, 0};
    vecs[2] = '{24578, 0};
    vecs[3] = '{36866, 12288};
    vecs[4] = '{49155, 12288};

    tick(acc); tick(acc);
    reset = 1'b0;
    tick(acc);

    // Reset state
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy",      int'(busy),      0);
    check("rst_err",       int'(err),       0);
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_data",  int'(out_data),  0);

    // Table vectors with 2-cycle latency
    lat_chk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].din, vecs[i].dout, 1'b1);
    end
    drain();
    check("table_err", int'(err), 0);

    // Streaming random inputs, in_valid held high
    for (int i = 0; i < 100; i++) begin
      d = int'($urandom_range(49155, 0));
      set_in(d, d % Q, 1'b1);
      tick(acc);
      check("stream_accept", int'(acc), 1);
    end
    drain();
    lat_chk = 1'b0;

    // Backpressure: 6 offered, only 4 fit
    bp_vals = '{100, 12300, 30000, 40000, 5, 49000};
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      set_in(bp_vals[k], bp_vals[k] % Q, 1'b1);
      tick(acc);
      if (acc) k++;
    end
    check("bp_accepted", k, 4);
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_busy",     int'(busy),     1);
    check("bp_out_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    nacc = 0;
    while (k < 6 && nacc < 20) begin
      set_in(bp_vals[k], bp_vals[k] % Q, 1'b1);
      tick(acc);
      if (acc) k++;
      nacc++;
    end
    check("bp_all_accepted", k, 6);
    drain();

    // Simultaneous push/pop with two entries held in the FIFO
    out_ready = 1'b0;
    send(1000, 1000, 1'b1);
    send(20000, 20000 % Q, 1'b1);
    tick(acc);
    send(30001, 30001 % Q, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 7000 + i * 6000;
      set_in(d, d % Q, 1'b1);
      tick(acc);
      check("pp_accept",    int'(acc),       1);
      check("pp_out_valid", int'(out_valid), 1);
    end
    drain();

    // Illegal input sets sticky err
    send(49156, 0, 1'b0);
    check("err_set", int'(err), 1);
    send(12290, 1, 1'b1);
    send(3, 3, 1'b1);
    drain();
    check("err_sticky", int'(err), 1);

    // Reset mid-operation: S1 valid and FIFO count 3
    out_ready = 1'b0;
    send(11, 11, 1'b1);
    send(22, 22, 1'b1);
    send(33, 33, 1'b1);
    send(44, 44, 1'b1);
    check("pre_rst_in_ready", int'(in_ready), 0);
    reset = 1'b1;
    tick(acc);
    reset = 1'b0;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_busy",      int'(busy),      0);
    check("mid_rst_err",       int'(err),       0);
    check("mid_rst_in_ready",  int'(in_ready),  1);
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(12290, 1, 1'b1);
    drain();
    lat_chk = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
